// File: rtl/commit_reorder_mpu.sv
// In-order commit table: ring buffer of issued instructions, out-of-order completion on several
// ports, and up to RETIRE_WIDTH in-order retirements per cycle.
module commit_reorder_mpu #(
  parameter int unsigned NUM_ENTRY    = 16,
  parameter int unsigned ISSUE_NO_W   = 8,
  parameter int unsigned NUM_CPORT    = 2,
  parameter int unsigned RETIRE_WIDTH = 2,
  parameter int unsigned TAG_W        = $clog2(NUM_ENTRY)
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic                               I_Flush,
  input  logic                               I_Req_Issue,
  input  logic [ISSUE_NO_W-1:0]              I_Issue_No,
  output logic                               O_Issue_Ack,
  output logic [TAG_W-1:0]                   O_Issue_Tag,
  input  logic [NUM_CPORT-1:0]               I_Req_Commit,
  input  logic [NUM_CPORT*TAG_W-1:0]         I_Commit_Tag,
  output logic [RETIRE_WIDTH-1:0]            O_Retire_Valid,
  output logic [RETIRE_WIDTH*ISSUE_NO_W-1:0] O_Retire_No,
  output logic                               O_Commit_Err,
  output logic                               O_Full,
  output logic                               O_Empty,
  output logic [TAG_W:0]                     O_Num
);

  localparam int unsigned CntW = TAG_W + 1;

  logic [NUM_ENTRY-1:0]                valid_q, valid_d;
  logic [NUM_ENTRY-1:0]                done_q, done_d;
  logic [ISSUE_NO_W-1:0]               issue_no_q [NUM_ENTRY];
  logic [TAG_W-1:0]                    head_q, head_d;
  logic [TAG_W-1:0]                    tail_q, tail_d;
  logic [CntW-1:0]                     count_q, count_d;
  logic [RETIRE_WIDTH-1:0]             retire_valid_q, retire_valid_d;
  logic [RETIRE_WIDTH*ISSUE_NO_W-1:0]  retire_no_q, retire_no_d;
  logic                                commit_err_q, commit_err_d;

  logic                                full;
  logic                                issue_ack;
  logic [CntW-1:0]                     retire_cnt;
  logic [NUM_ENTRY-1:0]                retire_mask;
  logic [NUM_ENTRY-1:0]                complete_mask;
  logic                                commit_err;

  assign full      = (count_q == CntW'(NUM_ENTRY));
  assign issue_ack = I_Req_Issue & ~full & ~I_Flush;

  // Retire the run of Valid&Done entries starting at head, capped at RETIRE_WIDTH and count.
  always_comb begin
    logic             run;
    logic [TAG_W-1:0] idx;
    run            = 1'b1;
    idx            = '0;
    retire_cnt     = '0;
    retire_mask    = '0;
    retire_valid_d = '0;
    retire_no_d    = '0;
    for (int i = 0; i < RETIRE_WIDTH; i++) begin
      idx = head_q + TAG_W'(i);
      if (run && valid_q[idx] && done_q[idx] && (CntW'(i) < count_q)) begin
        retire_mask[idx]                            = 1'b1;
        retire_valid_d[i]                           = 1'b1;
        retire_no_d[i*ISSUE_NO_W +: ISSUE_NO_W]     = issue_no_q[idx];
        retire_cnt                                  = retire_cnt + CntW'(1);
      end else begin
        run = 1'b0;
      end
    end
  end

  // A second port naming an entry already claimed this cycle counts as a duplicate.
  always_comb begin
    logic [TAG_W-1:0] tag;
    tag           = '0;
    complete_mask = '0;
    commit_err    = 1'b0;
    for (int p = 0; p < NUM_CPORT; p++) begin
      tag = I_Commit_Tag[p*TAG_W +: TAG_W];
      if (I_Req_Commit[p]) begin
        if (valid_q[tag] && !done_q[tag] && !complete_mask[tag]) begin
          complete_mask[tag] = 1'b1;
        end else begin
          commit_err = 1'b1;
        end
      end
    end
  end

  always_comb begin
    valid_d      = valid_q & ~retire_mask;
    done_d       = (done_q & ~retire_mask) | complete_mask;
    head_d       = head_q + retire_cnt[TAG_W-1:0];
    tail_d       = tail_q;
    count_d      = count_q + CntW'(issue_ack) - retire_cnt;
    commit_err_d = commit_err;
    if (issue_ack) begin
      valid_d[tail_q] = 1'b1;
      done_d[tail_q]  = 1'b0;
      tail_d          = tail_q + TAG_W'(1);
    end
  end

  // Flush shares the reset path, so errors raised in the flush cycle are discarded too.
  always_ff @(posedge clock) begin
    if (reset || I_Flush) begin
      valid_q        <= '0;
      done_q         <= '0;
      head_q         <= '0;
      tail_q         <= '0;
      count_q        <= '0;
      retire_valid_q <= '0;
      retire_no_q    <= '0;
      commit_err_q   <= 1'b0;
    end else begin
      valid_q        <= valid_d;
      done_q         <= done_d;
      head_q         <= head_d;
      tail_q         <= tail_d;
      count_q        <= count_d;
      retire_valid_q <= retire_valid_d;
      retire_no_q    <= retire_no_d;
      commit_err_q   <= commit_err_d;
    end
  end

  always_ff @(posedge clock) begin
    if (issue_ack) begin
      issue_no_q[tail_q] <= I_Issue_No;
    end
  end

  assign O_Issue_Ack    = issue_ack;
  assign O_Issue_Tag    = tail_q;
  assign O_Retire_Valid = retire_valid_q;
  assign O_Retire_No    = retire_no_q;
  assign O_Commit_Err   = commit_err_q;
  assign O_Full         = full;
  assign O_Empty        = (count_q == '0);
  assign O_Num          = count_q;

endmodule
